// File: rtl/fnms_issue_ctrl.sv
// Issue/collect stage around the C - A*B datapath: credit-checked operand issue,
// LATENCY-deep token pipe and result FIFO. Define FNMS_NAN_FLAG_EN to add out_nan.
module fnms_issue_ctrl #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_c,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    output logic [31:0] dp_c,
    output logic        dp_en,
    input  logic [31:0] dp_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
`ifdef FNMS_NAN_FLAG_EN
    output logic        out_nan,
`endif
    output logic        busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [LATENCY-1:0] tok;
    logic [LATENCY-1:0] tok_nxt;
    logic [CW-1:0]      in_flight;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        credit_used;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [31:0]        mem [FIFO_DEPTH];
    logic               issue;
    logic               tok_exit;
    logic               pop;

    // Credit counts both in-flight ops and queued results, so every token
    // that exits the pipe is guaranteed a free FIFO slot.
    assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
    assign in_ready    = !rst && (credit_used < (CW + 1)'(FIFO_DEPTH));
    assign issue       = in_valid && in_ready;
    assign tok_exit    = tok[LATENCY-1];
    assign out_valid   = (fifo_count != '0);
    assign pop         = out_valid && out_ready;
    assign out_result  = out_valid ? mem[rd_ptr] : '0;
    assign busy        = (in_flight != '0) || (fifo_count != '0);

    always_comb begin
        tok_nxt    = '0;
        tok_nxt[0] = issue;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tok_nxt[i] = tok[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_a       <= '0;
            dp_b       <= '0;
            dp_c       <= '0;
            dp_en      <= 1'b0;
            tok        <= '0;
            in_flight  <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (issue) begin
                dp_a <= in_a;
                dp_b <= in_b;
                dp_c <= in_c;
            end
            tok   <= tok_nxt;
            dp_en <= |tok_nxt;

            case ({issue, tok_exit})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: ;
            endcase

            case ({tok_exit, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase

            if (tok_exit) wr_ptr <= wr_ptr + PW'(1);
            if (pop)      rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: out_result is gated by fifo_count.
    always_ff @(posedge clk) begin
        if (!rst && tok_exit) begin
            mem[wr_ptr] <= dp_result;
        end
    end

`ifdef FNMS_NAN_FLAG_EN
    logic nan_mem [FIFO_DEPTH];
    logic res_is_nan;

    assign res_is_nan = (dp_result[30:23] == 8'hFF) && (dp_result[22:0] != '0);
    assign out_nan    = out_valid ? nan_mem[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst && tok_exit) begin
            nan_mem[wr_ptr] <= res_is_nan;
        end
    end
`endif

endmodule

// File: tb/tb_fnms_issue_ctrl.sv
// Scoreboard bench for fnms_issue_ctrl with a 2-cycle C - A*B datapath model;
// honours FNMS_NAN_FLAG_EN for the out_nan checks.
module tb_fnms_issue_ctrl;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] res;
        logic        nan;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b, in_c;
    logic [31:0] dp_a, dp_b, dp_c;
    logic        dp_en;
    logic [31:0] dp_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;
`ifdef FNMS_NAN_FLAG_EN
    logic        out_nan;
`endif

    int   n_vec  = 0;
    int   n_miss = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    logic [31:0] va [16];
    logic [31:0] vb [16];
    logic [31:0] vc [16];
    logic [31:0] vr [16];

    fnms_issue_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_c       (dp_c),
        .dp_en      (dp_en),
        .dp_result  (dp_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
`ifdef FNMS_NAN_FLAG_EN
        .out_nan    (out_nan),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Datapath model: exact for small integer-valued operands, NaN propagates.
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic real sp2r(input logic [31:0] x);
        logic [10:0] e11;
        if (x[30:23] == 8'd0) return 0.0;
        e11 = 11'(x[30:23]) + 11'd896;
        return $bitstoreal({x[31], e11, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] bits;
        logic [10:0] e11;
        if (r == 0.0) return 32'd0;
        bits = $realtobits(r);
        e11  = bits[62:52] - 11'd896;
        return {bits[63], e11[7:0], bits[51:29]};
    endfunction

    function automatic logic [31:0] fnms(input logic [31:0] a, b, c);
        if (is_nan(a) || is_nan(b) || is_nan(c)) return 32'h7FC00000;
        return r2sp(sp2r(c) - sp2r(a) * sp2r(b));
    endfunction

    logic [31:0] dp_stage = 32'd0;
    always @(posedge clk) dp_stage <= fnms(dp_a, dp_b, dp_c);
    assign dp_result = dp_en ? dp_stage : 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Monitor: a transfer is committed at the posedge following this negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        bound_fail("unexpected_result");
                    end else begin
                        chk("credit_bound", 32'(sb.size() <= DEPTH), 32'd1);
                        e = sb.pop_front();
                        chk("result", out_result, e.res);
`ifdef FNMS_NAN_FLAG_EN
                        chk("nan_flag", 32'(out_nan), 32'(e.nan));
`endif
                    end
                end else if (!out_valid) begin
                    chk("idle_result", out_result, 32'd0);
                end
            end
        end
    end

    task automatic issue_op(input logic [31:0] a, b, c, r, input logic n, output int waits);
        exp_t e;
        waits    = 0;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.res = r;
                e.nan = n;
                sb.push_back(e);
                break;
            end
            waits++;
            if (waits > 60) begin
                bound_fail("issue_wait");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_vec(input int idx, output int waits);
        issue_op(va[idx], vb[idx], vc[idx], vr[idx], 1'b0, waits);
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) bound_fail(name);
        @(negedge clk);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_dp_en"}, 32'(dp_en), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        // {A, B, C, C - A*B}, hand-encoded IEEE-754 singles
        va[0]  = 32'h40000000; vb[0]  = 32'h40400000; vc[0]  = 32'h3F800000; vr[0]  = 32'hC0A00000;
        va[1]  = 32'h3F800000; vb[1]  = 32'h3F800000; vc[1]  = 32'h00000000; vr[1]  = 32'hBF800000;
        va[2]  = 32'h40000000; vb[2]  = 32'h40000000; vc[2]  = 32'h41000000; vr[2]  = 32'h40800000;
        va[3]  = 32'h3F800000; vb[3]  = 32'h40000000; vc[3]  = 32'h40400000; vr[3]  = 32'h3F800000;
        va[4]  = 32'h40000000; vb[4]  = 32'h40800000; vc[4]  = 32'h00000000; vr[4]  = 32'hC1000000;
        va[5]  = 32'h40400000; vb[5]  = 32'h40400000; vc[5]  = 32'h3F800000; vr[5]  = 32'hC1000000;
        va[6]  = 32'hBF800000; vb[6]  = 32'h40000000; vc[6]  = 32'h00000000; vr[6]  = 32'h40000000;
        va[7]  = 32'hC0000000; vb[7]  = 32'hC0400000; vc[7]  = 32'h40800000; vr[7]  = 32'hC0000000;
        va[8]  = 32'h3F800000; vb[8]  = 32'h40800000; vc[8]  = 32'h40C00000; vr[8]  = 32'h40000000;
        va[9]  = 32'h40000000; vb[9]  = 32'h3F800000; vc[9]  = 32'h41100000; vr[9]  = 32'h40E00000;
        va[10] = 32'h40800000; vb[10] = 32'h40800000; vc[10] = 32'h41A00000; vr[10] = 32'h40800000;
        va[11] = 32'h40400000; vb[11] = 32'h40000000; vc[11] = 32'h41400000; vr[11] = 32'h40C00000;
        va[12] = 32'h3F800000; vb[12] = 32'h3F800000; vc[12] = 32'h3F800000; vr[12] = 32'h00000000;
        va[13] = 32'h40000000; vb[13] = 32'h40000000; vc[13] = 32'h00000000; vr[13] = 32'hC0800000;
        va[14] = 32'hBF800000; vb[14] = 32'hBF800000; vc[14] = 32'h41200000; vr[14] = 32'h41100000;
        va[15] = 32'h40800000; vb[15] = 32'h40000000; vc[15] = 32'h41800000; vr[15] = 32'h41000000;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp_en", 32'(dp_en), 32'd0);
        chk("rst_dp_a", dp_a, 32'd0);
        chk("rst_in_ready_released", 32'(in_ready), 32'd1);
`ifdef FNMS_NAN_FLAG_EN
        chk("rst_out_nan", 32'(out_nan), 32'd0);
`endif
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single op, latency of 2
        out_ready = 1'b1;
        issue_vec(0, w);
        @(negedge clk);
        chk("lat_dp_en", 32'(dp_en), 32'd1);
        chk("lat_dp_a", dp_a, va[0]);
        chk("lat_e1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_e2", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_visible", 32'(out_valid), 32'd1);
        drain("single");

        // Back-pressure: credit admits exactly DEPTH ops
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_vec(i, w);
            chk("bp_no_stall", 32'(w), 32'd0);
        end
        in_a = va[4]; in_b = vb[4]; in_c = vc[4]; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_credit_closed", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_before_pop", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_reopen", 32'(in_ready), 32'd1);
        if (in_ready) begin
            sb.push_back('{vr[4], 1'b0});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("backpressure");

        // Streaming: 16 back-to-back, pointers wrap four times
        for (int i = 0; i < 16; i++) begin
            issue_vec(i, w);
            chk("stream_stall", 32'(w), 32'd0);
        end
        drain("stream");

        // Reset mid-flight: one result queued, two in the pipe
        out_ready = 1'b0;
        for (int i = 5; i < 8; i++) issue_vec(i, w);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_dp_en", 32'(dp_en), 32'd0);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue_vec(9, w);
        drain("post_reset");

        // Simultaneous push/pop near full with toggling consumer
        fork
            begin
                for (int i = 0; i < 12; i++) issue_vec(i, w);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    out_ready = k[0];
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain("toggle");

`ifdef FNMS_NAN_FLAG_EN
        // NaN flag follows its own entry only
        issue_op(32'h7FC00000, 32'h3F800000, 32'h00000000, 32'h7FC00000, 1'b1, w);
        issue_vec(0, w);
        drain("nan");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
